// File: rtl/game_pkg.sv
// Shared game types: tile encoding, map geometry and map controller states.
package game_pkg;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        PLAYER1 = 3'd1,
        PLAYER2 = 3'd2,
        FRAME   = 3'd3,
        TEST    = 3'd4
    } tile_t;

    localparam int unsigned MAP_WIDTH  = 32;
    localparam int unsigned MAP_HEIGHT = 24;
    localparam int unsigned SIZE       = MAP_WIDTH * MAP_HEIGHT;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } map_ctrl_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Combinational one-hot grant from a registered pointer;
// the pointer moves to the other requester after every grant it issues.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt_onehot
);

    logic       rr_ptr;
    logic [1:0] eff_req;

    assign eff_req = req & ~mask;

    // Pick the winner: a lone requester wins, a tie goes to the pointer
    always_comb begin
        gnt_onehot = 2'b00;
        if (eff_req == 2'b11) begin
            gnt_onehot = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            gnt_onehot = eff_req;
        end
    end

    // Pointer moves away from whoever was just served
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt_onehot[0]) begin
            rr_ptr <= 1'b1;
        end else if (gnt_onehot[1]) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/map_write_arbiter.sv
// Sole writer of the tile map: clears it with a border sweep, then serves
// player trail writes one per cycle with collision detection.
module map_write_arbiter
    import game_pkg::*;
#(
    parameter int unsigned MAP_W = MAP_WIDTH,
    parameter int unsigned MAP_H = MAP_HEIGHT,
    parameter int unsigned XW    = $clog2(MAP_W),
    parameter int unsigned YW    = $clog2(MAP_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           req,
    input  logic [1:0][XW-1:0]   req_x,
    input  logic [1:0][YW-1:0]   req_y,
    output logic [1:0]           grant,
    output logic [1:0]           collide,
    output logic [1:0]           crashed,
    output logic                 busy,
    output tile_t                map [MAP_W][MAP_H]
);

    localparam int unsigned XI = $clog2(MAP_W);
    localparam int unsigned YI = $clog2(MAP_H);

    map_ctrl_state_t state, state_nx;
    logic [XI-1:0]   sx, sx_nx;
    logic [YI-1:0]   sy, sy_nx;
    logic [1:0]      grant_nx, collide_nx, crashed_nx;

    logic [1:0]      arb_mask_c;
    logic [1:0]      gnt_c;
    logic            sel_c;
    logic [XW-1:0]   tx_c;
    logic [YW-1:0]   ty_c;
    logic            oob_c;
    tile_t           cur_tile_c;
    logic            hit_c;
    logic            border_c;

    logic            wr_en_c;
    logic [XI-1:0]   wr_x_c;
    logic [YI-1:0]   wr_y_c;
    tile_t           wr_tile_c;

    // Nobody is arbitrated while clearing, on a restart, or right after being served
    assign arb_mask_c = grant | {2{(state != RUN) || start}};

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask       (arb_mask_c),
        .gnt_onehot (gnt_c)
    );

    // Target of the winning requester and its collision status
    assign sel_c      = gnt_c[1];
    assign tx_c       = req_x[sel_c];
    assign ty_c       = req_y[sel_c];
    assign oob_c      = (32'(tx_c) >= MAP_W) || (32'(ty_c) >= MAP_H);
    assign cur_tile_c = map[XI'(tx_c)][YI'(ty_c)];
    assign hit_c      = oob_c || (cur_tile_c != EMPTY);
    assign border_c   = (sx == '0) || (sx == XI'(MAP_W - 1)) ||
                        (sy == '0) || (sy == YI'(MAP_H - 1));

    // Next-state, sweep, service and map-write decode
    always_comb begin
        state_nx   = state;
        sx_nx      = sx;
        sy_nx      = sy;
        grant_nx   = 2'b00;
        collide_nx = 2'b00;
        crashed_nx = crashed;
        wr_en_c    = 1'b0;
        wr_x_c     = sx;
        wr_y_c     = sy;
        wr_tile_c  = EMPTY;

        if (start) begin
            state_nx   = CLEAR;
            sx_nx      = '0;
            sy_nx      = '0;
            crashed_nx = 2'b00;
        end else begin
            case (state)
                CLEAR: begin
                    wr_en_c   = 1'b1;
                    wr_tile_c = border_c ? FRAME : EMPTY;
                    if (sx == XI'(MAP_W - 1)) begin
                        sx_nx = '0;
                        if (sy == YI'(MAP_H - 1)) begin
                            sy_nx    = '0;
                            state_nx = RUN;
                        end else begin
                            sy_nx = sy + YI'(1);
                        end
                    end else begin
                        sx_nx = sx + XI'(1);
                    end
                end
                RUN: begin
                    if (gnt_c != 2'b00) begin
                        grant_nx = gnt_c;
                        if (hit_c) begin
                            collide_nx = gnt_c;
                            crashed_nx = crashed | gnt_c;
                        end else begin
                            wr_en_c   = 1'b1;
                            wr_x_c    = XI'(tx_c);
                            wr_y_c    = YI'(ty_c);
                            wr_tile_c = sel_c ? PLAYER2 : PLAYER1;
                        end
                    end
                end
                default: state_nx = CLEAR;
            endcase
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            sx      <= '0;
            sy      <= '0;
            grant   <= 2'b00;
            collide <= 2'b00;
            crashed <= 2'b00;
            busy    <= 1'b1;
        end else begin
            state   <= state_nx;
            sx      <= sx_nx;
            sy      <= sy_nx;
            grant   <= grant_nx;
            collide <= collide_nx;
            crashed <= crashed_nx;
            busy    <= (state_nx == CLEAR);
        end
    end

    // Map storage; contents only meaningful once the sweep has completed
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            map[wr_x_c][wr_y_c] <= wr_tile_c;
        end
    end

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter: clear sweep, arbitration, collisions, restart.
module tb_map_write_arbiter;
    import game_pkg::*;

    localparam int unsigned XW = 6;
    localparam int unsigned YW = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [1:0]          req;
    logic [1:0][XW-1:0]  req_x;
    logic [1:0][YW-1:0]  req_y;
    logic [1:0]          grant;
    logic [1:0]          collide;
    logic [1:0]          crashed;
    logic                busy;
    tile_t               map [MAP_WIDTH][MAP_HEIGHT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    map_write_arbiter #(
        .MAP_W (MAP_WIDTH),
        .MAP_H (MAP_HEIGHT),
        .XW    (XW),
        .YW    (YW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .req     (req),
        .req_x   (req_x),
        .req_y   (req_y),
        .grant   (grant),
        .collide (collide),
        .crashed (crashed),
        .busy    (busy),
        .map     (map)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count negedges with busy high; also note any grant seen meanwhile
    task automatic wait_clear(output int n, output int gseen);
        n = 0;
        gseen = 0;
        while (busy && n < 2000) begin
            n++;
            if (grant != 2'b00) gseen++;
            @(negedge clk);
        end
    endtask

    task automatic check_frame();
        for (int x = 0; x < int'(MAP_WIDTH); x++) begin
            for (int y = 0; y < int'(MAP_HEIGHT); y++) begin
                tile_t e;
                e = (x == 0 || x == 31 || y == 0 || y == 23) ? FRAME : EMPTY;
                check("clr_map", int'(map[x][y]), int'(e));
            end
        end
    endtask

    initial begin
        int n;
        int gs;
        rst   = 1'b1;
        start = 1'b0;
        req   = 2'b00;
        req_x = '0;
        req_y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", int'(busy), 1);
        check("rst_grant", int'(grant), 0);
        check("rst_collide", int'(collide), 0);
        check("rst_crashed", int'(crashed), 0);

        // Clear sweep length and contents
        wait_clear(n, gs);
        check("clr_len", n, 768);
        check("clr_nogrant", gs, 0);
        check_frame();

        // Both request (7,7): P1 wins and writes, P2 collides next cycle
        req      = 2'b11;
        req_x[0] = 6'd7; req_y[0] = 5'd7;
        req_x[1] = 6'd7; req_y[1] = 5'd7;
        @(negedge clk);
        check("tie_g1", int'(grant), 1);
        check("tie_c1", int'(collide), 0);
        check("tie_m1", int'(map[7][7]), int'(PLAYER1));
        req = 2'b10;
        @(negedge clk);
        check("tie_g2", int'(grant), 2);
        check("tie_c2", int'(collide), 2);
        check("tie_cr2", int'(crashed), 2);
        check("tie_m2", int'(map[7][7]), int'(PLAYER1));
        req = 2'b00;
        @(negedge clk);
        check("tie_g3", int'(grant), 0);

        // Single P1 write to (5,5)
        req      = 2'b01;
        req_x[0] = 6'd5; req_y[0] = 5'd5;
        @(negedge clk);
        check("p1_grant", int'(grant), 1);
        check("p1_collide", int'(collide), 0);
        check("p1_map", int'(map[5][5]), int'(PLAYER1));
        check("p1_crashed", int'(crashed), 2);
        req = 2'b00;
        @(negedge clk);
        check("p1_pulse", int'(grant), 0);

        // Continuous requests from both: pointer is at P2 now, grants alternate
        req      = 2'b11;
        req_x[0] = 6'd10; req_y[0] = 5'd10;
        req_x[1] = 6'd10; req_y[1] = 5'd12;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("alt_grant", int'(grant), (k % 2 == 0) ? 2 : 1);
            check("alt_collide", int'(collide), 0);
            if (grant[0]) req_x[0] = req_x[0] + 6'd1;
            if (grant[1]) req_x[1] = req_x[1] + 6'd1;
        end
        req = 2'b00;
        @(negedge clk);
        check("alt_idle", int'(grant), 0);
        check("alt_m_p1", int'(map[13][10]), int'(PLAYER1));
        check("alt_m_p2", int'(map[13][12]), int'(PLAYER2));

        // P2 into the frame, then out of range
        req      = 2'b10;
        req_x[1] = 6'd0; req_y[1] = 5'd3;
        @(negedge clk);
        check("frm_grant", int'(grant), 2);
        check("frm_collide", int'(collide), 2);
        check("frm_map", int'(map[0][3]), int'(FRAME));
        req = 2'b00;
        @(negedge clk);
        req      = 2'b10;
        req_x[1] = 6'd40; req_y[1] = 5'd3;
        @(negedge clk);
        check("oob_grant", int'(grant), 2);
        check("oob_collide", int'(collide), 2);
        check("oob_map", int'(map[8][3]), int'(EMPTY));
        check("oob_crashed", int'(crashed), 2);
        req = 2'b00;
        @(negedge clk);

        // Restart in RUN with P1 request held
        req      = 2'b01;
        req_x[0] = 6'd20; req_y[0] = 5'd20;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("st_busy", int'(busy), 1);
        check("st_grant", int'(grant), 0);
        check("st_crashed", int'(crashed), 0);
        wait_clear(n, gs);
        check("st_len", n, 768);
        check("st_nogrant", gs, 0);
        check("st_fall_grant", int'(grant), 0);
        check("st_m77", int'(map[7][7]), int'(EMPTY));
        check("st_m00", int'(map[0][0]), int'(FRAME));
        @(negedge clk);
        check("st_held_grant", int'(grant), 1);
        check("st_held_map", int'(map[20][20]), int'(PLAYER1));
        req = 2'b00;
        @(negedge clk);

        // Reset with a request in flight: not granted
        req      = 2'b10;
        req_x[1] = 6'd15; req_y[1] = 5'd15;
        rst      = 1'b1;
        @(negedge clk);
        check("rr_grant", int'(grant), 0);
        check("rr_busy", int'(busy), 1);
        check("rr_crashed", int'(crashed), 0);
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
